// File: rtl/bus_drive_arbiter.sv
// Round-robin arbiter for a shared multi-driver bus: one-hot registered grant/oe,
// per-grant hold limit with timeout pulse, and a fixed all-off turnaround gap.
// Optional bus keeper enable is built only when BUS_KEEPER_EN is defined.
module bus_drive_arbiter #(
    parameter int N_REQ      = 4,
    parameter int TURNAROUND = 1,
    parameter int MAX_HOLD   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [N_REQ-1:0] oe,
    output logic             busy,
    output logic             timeout,
    output logic             keeper_en
);

    localparam int PW = $clog2(N_REQ);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam int TW = $clog2(TURNAROUND + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        TURN  = 2'd2
    } state_t;

    // First set request at or above ptr, wrapping; smallest offset assigned last wins.
    function automatic logic [PW-1:0] pick_winner(input logic [N_REQ-1:0] r,
                                                  input logic [PW-1:0]    ptr);
        logic [PW-1:0] win;
        logic [PW-1:0] idx;
        int            sum;
        win = ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            sum = int'(ptr) + k;
            sum = (sum >= N_REQ) ? (sum - N_REQ) : sum;
            idx = PW'(sum);
            win = r[idx] ? idx : win;
        end
        return win;
    endfunction

    state_t          state_r, state_s;
    logic [HW-1:0]   hold_cnt_r, hold_cnt_s;
    logic [TW-1:0]   turn_cnt_r, turn_cnt_s;
    logic [PW-1:0]   rr_ptr_r, rr_ptr_s;
    logic [PW-1:0]   win_s;
    logic [N_REQ-1:0] gnt_s;
    logic            timeout_s;

    // Next-state, next-grant and counter logic.
    always_comb begin
        state_s    = state_r;
        gnt_s      = gnt;
        hold_cnt_s = hold_cnt_r;
        turn_cnt_s = turn_cnt_r;
        rr_ptr_s   = rr_ptr_r;
        timeout_s  = 1'b0;
        win_s      = pick_winner(req, rr_ptr_r);
        case (state_r)
            IDLE: begin
                if (|req) begin
                    state_s    = DRIVE;
                    gnt_s      = {{(N_REQ-1){1'b0}}, 1'b1} << win_s;
                    rr_ptr_s   = (win_s == PW'(N_REQ - 1)) ? {PW{1'b0}} : (win_s + PW'(1));
                    hold_cnt_s = HW'(1);
                end else begin
                    gnt_s      = {N_REQ{1'b0}};
                    hold_cnt_s = {HW{1'b0}};
                end
            end
            DRIVE: begin
                if (~|(req & gnt)) begin
                    state_s    = TURN;
                    gnt_s      = {N_REQ{1'b0}};
                    hold_cnt_s = {HW{1'b0}};
                    turn_cnt_s = TW'(1);
                end else if (hold_cnt_r == HW'(MAX_HOLD)) begin
                    state_s    = TURN;
                    gnt_s      = {N_REQ{1'b0}};
                    hold_cnt_s = {HW{1'b0}};
                    turn_cnt_s = TW'(1);
                    timeout_s  = 1'b1;
                end else begin
                    hold_cnt_s = hold_cnt_r + HW'(1);
                end
            end
            TURN: begin
                gnt_s = {N_REQ{1'b0}};
                if (turn_cnt_r == TW'(TURNAROUND)) begin
                    state_s    = IDLE;
                    turn_cnt_s = {TW{1'b0}};
                end else begin
                    turn_cnt_s = turn_cnt_r + TW'(1);
                end
            end
            default: begin
                state_s    = IDLE;
                gnt_s      = {N_REQ{1'b0}};
                hold_cnt_s = {HW{1'b0}};
                turn_cnt_s = {TW{1'b0}};
            end
        endcase
    end

    // State, counters and registered bus-facing outputs; reset drops oe on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            hold_cnt_r <= {HW{1'b0}};
            turn_cnt_r <= {TW{1'b0}};
            rr_ptr_r   <= {PW{1'b0}};
            gnt        <= {N_REQ{1'b0}};
            oe         <= {N_REQ{1'b0}};
            busy       <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state_r    <= state_s;
            hold_cnt_r <= hold_cnt_s;
            turn_cnt_r <= turn_cnt_s;
            rr_ptr_r   <= rr_ptr_s;
            gnt        <= gnt_s;
            oe         <= gnt_s;
            busy       <= |gnt_s;
            timeout    <= timeout_s;
        end
    end

`ifdef BUS_KEEPER_EN
    logic keeper_r;

    // Keeper holds the bus whenever no strong driver is enabled, including reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            keeper_r <= 1'b1;
        end else begin
            keeper_r <= ~|gnt_s;
        end
    end

    assign keeper_en = keeper_r;
`else
    assign keeper_en = 1'b0;
`endif

endmodule

// File: tb/tb_bus_drive_arbiter.sv
// Scoreboard bench for bus_drive_arbiter (N_REQ=4, TURNAROUND=1, MAX_HOLD=4):
// a cycle model pushes expected outputs as each cycle is driven; tasks pop and compare.
module tb_bus_drive_arbiter;

    localparam int N_REQ      = 4;
    localparam int TURNAROUND = 1;
    localparam int MAX_HOLD   = 4;
`ifdef BUS_KEEPER_EN
    localparam logic KEEP_RST = 1'b1;
`else
    localparam logic KEEP_RST = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt, oe;
    logic       busy, timeout, keeper_en;

    int n_checks = 0;
    int n_pass   = 0;

    logic [10:0] sb_q[$];

    int         m_state = 0;
    int         m_gi = 0;
    int         m_hold = 0;
    int         m_ptr = 0;
    int         m_turn = 0;
    logic [3:0] m_gnt = 4'b0000;
    logic       m_to = 1'b0;

    bus_drive_arbiter #(.N_REQ(N_REQ), .TURNAROUND(TURNAROUND), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .oe(oe),
        .busy(busy), .timeout(timeout), .keeper_en(keeper_en)
    );

    always #5 clk = ~clk;

    // Drive one cycle, advance the model, push its prediction, then step past the edge.
    task automatic drive_cycle(input logic rst, input logic [3:0] r);
        logic kexp;
        int   j;
        rst_n = rst;
        req   = r;
        if (!rst) begin
            m_state = 0; m_gnt = 4'b0000; m_hold = 0; m_ptr = 0; m_to = 1'b0; m_turn = 0;
        end else begin
            m_to = 1'b0;
            case (m_state)
                0: begin
                    for (int k = 0; k < 4; k++) begin
                        j = (m_ptr + k) % 4;
                        if (r[j[1:0]] && m_state == 0) begin
                            m_gi = j;
                            m_state = 1;
                        end
                    end
                    if (m_state == 1) begin
                        m_gnt  = 4'b0001 << m_gi;
                        m_ptr  = (m_gi + 1) % 4;
                        m_hold = 1;
                    end
                end
                1: begin
                    if (!r[m_gi]) begin
                        m_gnt = 4'b0000; m_state = 2; m_turn = TURNAROUND;
                    end else if (m_hold == MAX_HOLD) begin
                        m_gnt = 4'b0000; m_state = 2; m_turn = TURNAROUND; m_to = 1'b1;
                    end else begin
                        m_hold++;
                    end
                end
                2: begin
                    m_turn--;
                    if (m_turn == 0) m_state = 0;
                end
                default: m_state = 0;
            endcase
        end
`ifdef BUS_KEEPER_EN
        kexp = ~|m_gnt;
`else
        kexp = 1'b0;
`endif
        sb_q.push_back({m_gnt, m_gnt, |m_gnt, m_to, kexp});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [10:0] exp, obs;
        for (int c = 0; c < 3; c++) begin
            drive_cycle(1'b0, 4'b1111);
            exp = sb_q.pop_front();
            obs = {gnt, oe, busy, timeout, keeper_en};
            n_checks++;
            if (obs !== exp) $display("FAIL reset c%0d: got %b expected %b", c, obs, exp);
            else n_pass++;
        end
        n_checks++;
        if (keeper_en !== KEEP_RST) $display("FAIL reset_keeper: got %b expected %b", keeper_en, KEEP_RST);
        else n_pass++;
    endtask

    task automatic test_single();
        logic [10:0] exp, obs;
        for (int c = 0; c < 10; c++) begin
            drive_cycle(c >= 2, (c >= 2 && c < 6) ? 4'b0100 : 4'b0000);
            exp = sb_q.pop_front();
            obs = {gnt, oe, busy, timeout, keeper_en};
            n_checks++;
            if (obs !== exp) $display("FAIL single c%0d: got %b expected %b", c, obs, exp);
            else n_pass++;
            if (c == 2) begin
                n_checks++;
                if (gnt !== 4'b0100 || oe !== 4'b0100 || busy !== 1'b1)
                    $display("FAIL single_first: got gnt=%b oe=%b busy=%b expected 0100/0100/1", gnt, oe, busy);
                else n_pass++;
            end
        end
    endtask

    task automatic test_round_robin();
        logic [10:0] exp, obs;
        logic [3:0]  prev = 4'b0000;
        int n_gr = 0, n_to = 0, gap = 0, run = 0;
        for (int c = 0; c < 42; c++) begin
            drive_cycle(c >= 2, 4'b1111);
            exp = sb_q.pop_front();
            obs = {gnt, oe, busy, timeout, keeper_en};
            n_checks++;
            if (obs !== exp) $display("FAIL rr c%0d: got %b expected %b", c, obs, exp);
            else n_pass++;
            if (c >= 2) begin
                if (gnt !== 4'b0000 && prev === 4'b0000) begin
                    n_checks++;
                    if (gnt !== (4'b0001 << (n_gr % 4)) || (n_gr > 0 && gap != 2))
                        $display("FAIL rr_order grant %0d: got gnt=%b gap=%0d expected %b gap 2", n_gr, gnt, gap, 4'b0001 << (n_gr % 4));
                    else n_pass++;
                    n_gr++; gap = 0; run = 0;
                end
                if (gnt === 4'b0000 && prev !== 4'b0000) begin
                    n_checks++;
                    if (run != 4) $display("FAIL rr_hold: got %0d cycles expected 4", run);
                    else n_pass++;
                end
                if (gnt === 4'b0000) gap++;
                else run++;
                if (timeout === 1'b1) n_to++;
                prev = gnt;
            end
        end
        n_checks++;
        if (n_gr != 7 || n_to != 6) $display("FAIL rr_counts: got grants=%0d timeouts=%0d expected 7/6", n_gr, n_to);
        else n_pass++;
    endtask

    task automatic test_drop();
        logic [10:0] exp, obs;
        logic [3:0]  r;
        for (int c = 0; c < 9; c++) begin
            r = (c == 2) ? 4'b0010 : (c == 3) ? 4'b1010 : (c >= 4) ? 4'b1000 : 4'b0000;
            drive_cycle(c >= 2, r);
            exp = sb_q.pop_front();
            obs = {gnt, oe, busy, timeout, keeper_en};
            n_checks++;
            if (obs !== exp) $display("FAIL drop c%0d: got %b expected %b", c, obs, exp);
            else n_pass++;
            if (c == 4 || c == 5) begin
                n_checks++;
                if (gnt !== 4'b0000 || timeout !== 1'b0)
                    $display("FAIL drop_release c%0d: got gnt=%b timeout=%b expected 0000/0", c, gnt, timeout);
                else n_pass++;
            end
            if (c == 6) begin
                n_checks++;
                if (gnt !== 4'b1000) $display("FAIL drop_next: got %b expected 1000", gnt);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [10:0] exp, obs;
        for (int c = 0; c < 9; c++) begin
            drive_cycle(c >= 2 && c != 4, (c < 5) ? 4'b0100 : 4'b1001);
            exp = sb_q.pop_front();
            obs = {gnt, oe, busy, timeout, keeper_en};
            n_checks++;
            if (obs !== exp) $display("FAIL rstmid c%0d: got %b expected %b", c, obs, exp);
            else n_pass++;
            if (c == 4) begin
                n_checks++;
                if (oe !== 4'b0000 || timeout !== 1'b0)
                    $display("FAIL rstmid_oe: got oe=%b timeout=%b expected 0000/0", oe, timeout);
                else n_pass++;
            end
            if (c == 5) begin
                n_checks++;
                if (gnt !== 4'b0001) $display("FAIL rstmid_ptr: got %b expected 0001", gnt);
                else n_pass++;
            end
        end
    endtask

    task automatic test_sole_timeout();
        logic [10:0] exp, obs;
        logic [3:0]  prev = 4'b0000;
        int n_gr = 0, n_to = 0, multi = 0;
        for (int c = 0; c < 16; c++) begin
            drive_cycle(c >= 2, (c >= 2) ? 4'b0100 : 4'b0000);
            exp = sb_q.pop_front();
            obs = {gnt, oe, busy, timeout, keeper_en};
            n_checks++;
            if (obs !== exp) $display("FAIL sole c%0d: got %b expected %b", c, obs, exp);
            else n_pass++;
            if ($countones(oe) > 1) multi++;
            if (c >= 2 && gnt !== 4'b0000 && prev === 4'b0000) n_gr++;
            if (timeout === 1'b1) n_to++;
            prev = gnt;
        end
        n_checks++;
        if (n_gr != 3 || n_to != 2 || multi != 0)
            $display("FAIL sole_counts: got grants=%0d timeouts=%0d multihot=%0d expected 3/2/0", n_gr, n_to, multi);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_drop();
        test_reset_mid();
        test_sole_timeout();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bus_drive_arbiter.md
BUS_DRIVE_ARBITER -- requirements
Module: bus_drive_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one multi-driver bus net; legal range 2..16.
REQ-002 Parameter TURNAROUND, default 1: idle cycles with no driver enabled between consecutive grants; legal range 1..8.
REQ-003 Parameter MAX_HOLD, default 16: maximum consecutive drive cycles per grant; legal range 1..255.
REQ-004 One clock; reset is synchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 req  input  N_REQ  level request per requester; bit i high means requester i wants to drive the bus.
REQ-008 gnt  output  N_REQ  registered grant; one-hot or zero.
REQ-009 oe  output  N_REQ  registered driver output-enable to the strong0/strong1 bus drivers; always equal to gnt.
REQ-010 busy  output  1  high while any oe bit is high.
REQ-011 timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.
REQ-012 keeper_en  output  1  enable for the weak0/weak1 bus keeper.

Function
REQ-013 The FSM SHALL have three states: IDLE, DRIVE and TURN.
REQ-014 In IDLE, if req is nonzero at edge t, the block SHALL enter DRIVE with gnt/oe one-hot at the winner from edge t+1 (1-cycle latency).
REQ-015 The winner SHALL be the first set req bit at or above rr_ptr, searching upward and wrapping past N_REQ-1 to 0.
REQ-016 On each grant to requester i, rr_ptr SHALL become (i+1) mod N_REQ; rr_ptr does not change in any other cycle.
REQ-017 In DRIVE, hold_cnt SHALL count drive cycles starting at 1 in the first DRIVE cycle; its width is clog2(MAX_HOLD+1).
REQ-018 In DRIVE, if req[granted] is low, the next state SHALL be TURN and gnt/oe SHALL clear on that edge.
REQ-019 In DRIVE, if req[granted] is high and hold_cnt==MAX_HOLD, the next state SHALL be TURN, gnt/oe SHALL clear, and timeout SHALL pulse high for exactly that next cycle.
REQ-020 Requests from other requesters SHALL NOT preempt an active grant.
REQ-021 TURN SHALL last exactly TURNAROUND cycles with gnt and oe all zero, then go to IDLE; req is ignored during TURN.
REQ-022 Minimum gap between a grant ending and the next grant starting: TURNAROUND+1 cycles with all oe low.
REQ-023 A requester revoked by timeout that keeps req high SHALL be re-eligible in IDLE; with no competitor it is re-granted.
REQ-024 oe SHALL never have more than one bit set in any cycle, including across reset release.
REQ-025 busy SHALL equal the OR-reduction of oe.

Reset
REQ-026 While rst_n is low at a clk edge: state=IDLE, gnt=0, oe=0, busy=0, timeout=0, hold_cnt=0, rr_ptr=0.
REQ-027 Reset asserted during DRIVE or TURN SHALL clear oe on the same edge with no TURN sequence.
REQ-028 keeper_en reset value: 1 when BUS_KEEPER_EN is defined, 0 otherwise.

Configuration
REQ-029 With macro BUS_KEEPER_EN defined, keeper_en SHALL be registered and high exactly when no oe bit is high (IDLE, TURN and reset).
REQ-030 Without BUS_KEEPER_EN, keeper_en SHALL be tied to constant 0 and no keeper logic is generated.
REQ-031 Grant, turnaround and timeout behaviour SHALL be identical with or without BUS_KEEPER_EN.

Verification (N_REQ=4, TURNAROUND=1, MAX_HOLD=4)
REQ-032 After reset, req=4'b0100 held -> gnt=4'b0100 on the next cycle; oe==gnt; busy=1.
REQ-033 req=4'b1111 held for 40 cycles -> grant order 0,1,2,3,0,...; each grant lasts 4 cycles with a timeout pulse at its end; exactly 1 all-zero TURN cycle plus 1 IDLE cycle between grants.
REQ-034 Requester 1 granted, then req[1] dropped at cycle 2 -> gnt=0 on the next edge, timeout stays 0; requester 3, requesting since cycle 1, is granted after TURN and IDLE.
REQ-035 rst_n driven low during DRIVE -> oe=0 on that edge; after release with req=4'b0001, gnt=4'b0001 one cycle after the first IDLE cycle; rr_ptr is back at 0.
REQ-036 Sole requester 2 held for 12 cycles -> grants of 4 cycles each with timeout pulses and 2-cycle gaps (TURN plus IDLE); oe is never multi-hot.
REQ-037 Build with BUS_KEEPER_EN -> keeper_en == ~busy every cycle and 1 during reset; build without it -> keeper_en constant 0.
